// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider with per-channel tick strobes.
// New divisors take effect at the channel's wrap or immediately on SYNC.
module clk_div_multi #(
  parameter int NCH         = 4,
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 100
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EN,
  input  logic             LOAD,
  input  logic [NCH-1:0]   LOAD_SEL,
  input  logic [WIDTH-1:0] DIV_IN,
  input  logic             SYNC,
  output logic [NCH-1:0]   CLK_OUT,
  output logic [NCH-1:0]   TICK,
  output logic [NCH-1:0]   PENDING,
  output logic             ERR
);

  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);

  logic load_ok;
  logic err_q, err_d;

  assign load_ok = LOAD && (DIV_IN >= TWO);

  always_comb begin
    err_d = err_q | (LOAD && (DIV_IN < TWO));
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign ERR = err_q;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] pend_div_q, pend_div_d;
    logic [WIDTH-1:0] nxt_div;
    logic             pending_q, pending_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             sel_load;

    // A load in the same cycle as a wrap or SYNC wins over any older pending value.
    always_comb begin
      sel_load   = load_ok && LOAD_SEL[g];
      nxt_div    = sel_load ? DIV_IN : (pending_q ? pend_div_q : div_q);
      pend_div_d = sel_load ? DIV_IN : pend_div_q;
      cnt_d      = cnt_q;
      div_d      = div_q;
      pending_d  = sel_load || pending_q;
      clk_out_d  = clk_out_q;
      tick_d     = 1'b0;
      if (EN) begin
        if (SYNC || (cnt_q == div_q - ONE)) begin
          cnt_d     = '0;
          div_d     = nxt_div;
          pending_d = 1'b0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
        clk_out_d = (cnt_d < (div_d >> 1));
        tick_d    = (cnt_d == div_d - ONE);
      end
    end

    always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
        cnt_q      <= DEF_DIV - ONE;
        div_q      <= DEF_DIV;
        pend_div_q <= DEF_DIV;
        pending_q  <= 1'b0;
        clk_out_q  <= 1'b0;
        tick_q     <= 1'b0;
      end else begin
        cnt_q      <= cnt_d;
        div_q      <= div_d;
        pend_div_q <= pend_div_d;
        pending_q  <= pending_d;
        clk_out_q  <= clk_out_d;
        tick_q     <= tick_d;
      end
    end

    assign CLK_OUT[g] = clk_out_q;
    assign TICK[g]    = tick_q;
    assign PENDING[g] = pending_q;
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: directed scenarios plus random traffic
// compared against a period/phase reference model.
module tb_clk_div_multi;
  localparam int NCH   = 4;
  localparam int WIDTH = 16;
  localparam int DEF   = 100;

  logic             CLK = 1'b0;
  logic             RESET;
  logic             EN;
  logic             LOAD;
  logic [NCH-1:0]   LOAD_SEL;
  logic [WIDTH-1:0] DIV_IN;
  logic             SYNC;
  logic [NCH-1:0]   CLK_OUT;
  logic [NCH-1:0]   TICK;
  logic [NCH-1:0]   PENDING;
  logic             ERR;

  int checks   = 0;
  int failures = 0;

  // Reference model: position within the current period and the period length
  int m_phase[NCH];
  int m_period[NCH];
  int m_pdiv[NCH];
  bit m_pend[NCH];
  bit m_clk[NCH];
  bit m_tick[NCH];
  bit m_err;

  always #5 CLK = ~CLK;

  clk_div_multi #(.NCH(NCH), .WIDTH(WIDTH), .DEFAULT_DIV(DEF)) dut (
    .CLK(CLK), .RESET(RESET), .EN(EN), .LOAD(LOAD), .LOAD_SEL(LOAD_SEL),
    .DIV_IN(DIV_IN), .SYNC(SYNC), .CLK_OUT(CLK_OUT), .TICK(TICK),
    .PENDING(PENDING), .ERR(ERR)
  );

  function automatic logic [3*NCH:0] model_vec();
    logic [NCH-1:0] c, t, p;
    for (int i = 0; i < NCH; i++) begin
      c[i] = m_clk[i];
      t[i] = m_tick[i];
      p[i] = m_pend[i];
    end
    return {c, t, p, m_err};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_phase[i] = DEF - 1; m_period[i] = DEF; m_pdiv[i] = DEF;
      m_pend[i] = 0; m_clk[i] = 0; m_tick[i] = 0;
    end
    m_err = 0;
  endtask

  task automatic model_step();
    int d;
    d = int'(DIV_IN);
    if (LOAD && d < 2) m_err = 1;
    for (int i = 0; i < NCH; i++) begin
      if (LOAD && d >= 2 && LOAD_SEL[i]) begin
        m_pdiv[i] = d;
        m_pend[i] = 1;
      end
      if (EN) begin
        if (SYNC || m_phase[i] == m_period[i] - 1) begin
          m_phase[i] = 0;
          if (m_pend[i]) m_period[i] = m_pdiv[i];
          m_pend[i] = 0;
        end else begin
          m_phase[i]++;
        end
        m_clk[i]  = (m_phase[i] < m_period[i] / 2);
        m_tick[i] = (m_phase[i] == m_period[i] - 1);
      end else begin
        m_tick[i] = 0;
      end
    end
  endtask

  task automatic step(input bit en, input bit ld, input logic [NCH-1:0] sel,
                      input int div, input bit sync);
    EN = en; LOAD = ld; LOAD_SEL = sel; DIV_IN = WIDTH'(div); SYNC = sync;
    @(posedge CLK);
    model_step();
    #1;
    LOAD = 1'b0; SYNC = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b0; EN = 1'b0; LOAD = 1'b0; SYNC = 1'b0; LOAD_SEL = '0; DIV_IN = '0;
    model_reset();
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  task automatic test_reset();
    RESET = 1'b0; EN = 1'b0; LOAD = 1'b0; SYNC = 1'b0; LOAD_SEL = '0; DIV_IN = '0;
    model_reset();
    #12;
    checks++;
    if ({CLK_OUT, TICK, PENDING, ERR} !== 13'h0) begin
      failures++;
      $display("FAIL reset_state: got %h expected %h", {CLK_OUT, TICK, PENDING, ERR}, 13'h0);
    end
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  task automatic test_defaults();
    int ticks[NCH];
    int highs;
    highs = 0;
    for (int i = 0; i < NCH; i++) ticks[i] = 0;
    for (int k = 0; k < 200; k++) begin
      step(1, 0, '0, 0, 0);
      if (k == 0) begin
        checks++;
        if (CLK_OUT !== 4'hF || TICK !== 4'h0) begin
          failures++;
          $display("FAIL first_edge: got clk=%h tick=%h expected clk=f tick=0", CLK_OUT, TICK);
        end
      end
      for (int i = 0; i < NCH; i++) ticks[i] += int'(TICK[i]);
      highs += int'(CLK_OUT[0]);
      checks++;
      if ({CLK_OUT, TICK, PENDING, ERR} !== model_vec()) begin
        failures++;
        $display("FAIL defaults k=%0d: got %h expected %h", k, {CLK_OUT, TICK, PENDING, ERR}, model_vec());
      end
    end
    for (int i = 0; i < NCH; i++) begin
      checks++;
      if (ticks[i] !== 2) begin
        failures++;
        $display("FAIL default_tick_count ch%0d: got %0d expected 2", i, ticks[i]);
      end
    end
    checks++;
    if (highs !== 100) begin
      failures++;
      $display("FAIL default_high_cycles: got %0d expected 100", highs);
    end
  endtask

  task automatic test_load_midperiod();
    do_reset();
    for (int k = 0; k < 31; k++) step(1, 0, '0, 0, 0);
    step(1, 1, 4'b0010, 5, 0);
    checks++;
    if (PENDING !== 4'b0010) begin
      failures++;
      $display("FAIL load_pending_rise: got %b expected 0010", PENDING);
    end
    for (int k = 1; k <= 80; k++) begin
      step(1, 0, '0, 0, 0);
      checks++;
      if (PENDING[1] !== (k <= 68)) begin
        failures++;
        $display("FAIL load_pending_hold k=%0d: got %b expected %b", k, PENDING[1], (k <= 68));
      end
      if (k >= 69) begin
        checks++;
        if (CLK_OUT[1] !== (((k - 69) % 5) < 2) || TICK[1] !== (((k - 69) % 5) == 4)) begin
          failures++;
          $display("FAIL div5_pattern k=%0d: got clk=%b tick=%b", k, CLK_OUT[1], TICK[1]);
        end
      end
      checks++;
      if ({CLK_OUT, TICK, PENDING, ERR} !== model_vec()) begin
        failures++;
        $display("FAIL load_mid k=%0d: got %h expected %h", k, {CLK_OUT, TICK, PENDING, ERR}, model_vec());
      end
    end
  endtask

  task automatic test_small_divisors();
    do_reset();
    step(1, 0, '0, 0, 0);
    step(1, 1, 4'b0001, 3, 0);
    step(1, 1, 4'b0010, 2, 1);
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) step(1, 0, '0, 0, 0);
      checks++;
      if (CLK_OUT[0] !== (k % 3 == 0) || TICK[0] !== (k % 3 == 2) ||
          CLK_OUT[1] !== (k % 2 == 0) || TICK[1] !== (k % 2 == 1) || PENDING !== 4'b0) begin
        failures++;
        $display("FAIL small_div k=%0d: got clk=%b tick=%b pend=%b", k, CLK_OUT[1:0], TICK[1:0], PENDING);
      end
    end
  endtask

  task automatic test_err();
    step(1, 1, 4'hF, 1, 0);
    checks++;
    if (ERR !== 1'b1 || PENDING !== 4'h0) begin
      failures++;
      $display("FAIL err_set: got err=%b pend=%b expected err=1 pend=0000", ERR, PENDING);
    end
    for (int k = 0; k < 10; k++) begin
      step(1, (k == 3), 4'hF, 0, 0);
      checks++;
      if ({CLK_OUT, TICK, PENDING, ERR} !== model_vec()) begin
        failures++;
        $display("FAIL err_hold k=%0d: got %h expected %h", k, {CLK_OUT, TICK, PENDING, ERR}, model_vec());
      end
    end
    step(1, 1, 4'b0100, 9, 0);
    checks++;
    if (ERR !== 1'b1 || PENDING[2] !== 1'b1) begin
      failures++;
      $display("FAIL err_then_load: got err=%b pend=%b expected err=1 pend[2]=1", ERR, PENDING);
    end
  endtask

  task automatic test_sync();
    int n;
    do_reset();
    step(1, 1, 4'b0100, 7, 0);
    step(1, 1, 4'b1000, 10, 0);
    n = 100 + $urandom_range(1, 9);
    for (int k = 0; k < n; k++) begin
      step(1, 0, '0, 0, 0);
      checks++;
      if ({CLK_OUT, TICK, PENDING, ERR} !== model_vec()) begin
        failures++;
        $display("FAIL sync_pre k=%0d: got %h expected %h", k, {CLK_OUT, TICK, PENDING, ERR}, model_vec());
      end
    end
    step(1, 0, '0, 0, 1);
    checks++;
    if (CLK_OUT[3:2] !== 2'b11 || TICK !== 4'h0) begin
      failures++;
      $display("FAIL sync_align: got clk=%b tick=%b expected clk[3:2]=11 tick=0000", CLK_OUT, TICK);
    end
    step(1, 1, 4'b0001, 4, 1);
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) step(1, 0, '0, 0, 0);
      checks++;
      if (PENDING[0] !== 1'b0 || CLK_OUT[0] !== ((k % 4) < 2) || TICK[0] !== ((k % 4) == 3)) begin
        failures++;
        $display("FAIL sync_load k=%0d: got pend=%b clk=%b tick=%b", k, PENDING[0], CLK_OUT[0], TICK[0]);
      end
    end
  endtask

  task automatic test_enable_hold();
    logic [NCH-1:0] held;
    for (int k = 0; k < 13; k++) step(1, 0, '0, 0, 0);
    held = CLK_OUT;
    for (int k = 0; k < 20; k++) begin
      step(0, (k == 5), 4'b0010, 6, (k == 9));
      checks++;
      if (CLK_OUT !== held || TICK !== 4'h0) begin
        failures++;
        $display("FAIL en_hold k=%0d: got clk=%b tick=%b expected clk=%b tick=0000", k, CLK_OUT, TICK, held);
      end
      if (k >= 5) begin
        checks++;
        if (PENDING[1] !== 1'b1) begin
          failures++;
          $display("FAIL en_low_load k=%0d: got pend[1]=%b expected 1", k, PENDING[1]);
        end
      end
    end
    for (int k = 0; k < 40; k++) begin
      step(1, 0, '0, 0, 0);
      checks++;
      if ({CLK_OUT, TICK, PENDING, ERR} !== model_vec()) begin
        failures++;
        $display("FAIL en_resume k=%0d: got %h expected %h", k, {CLK_OUT, TICK, PENDING, ERR}, model_vec());
      end
    end
  endtask

  task automatic test_reset_midperiod();
    int ticks;
    ticks = 0;
    do_reset();
    for (int k = 0; k < 20; k++) step(1, 0, '0, 0, 0);
    step(1, 1, 4'b0010, 6, 0);
    checks++;
    if (PENDING[1] !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_pending: got %b expected 1", PENDING[1]);
    end
    #2;
    RESET = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({CLK_OUT, TICK, PENDING, ERR} !== 13'h0) begin
      failures++;
      $display("FAIL rst_mid_async: got %h expected %h", {CLK_OUT, TICK, PENDING, ERR}, 13'h0);
    end
    @(negedge CLK);
    RESET = 1'b1;
    for (int k = 0; k < 100; k++) begin
      step(1, 0, '0, 0, 0);
      ticks += int'(TICK[1]);
      checks++;
      if ({CLK_OUT, TICK, PENDING, ERR} !== model_vec()) begin
        failures++;
        $display("FAIL rst_mid_after k=%0d: got %h expected %h", k, {CLK_OUT, TICK, PENDING, ERR}, model_vec());
      end
    end
    checks++;
    if (ticks !== 1) begin
      failures++;
      $display("FAIL rst_mid_default_div: got %0d ticks expected 1", ticks);
    end
  endtask

  task automatic test_random();
    bit en, ld, sy;
    int d;
    logic [NCH-1:0] sel;
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      en  = ($urandom_range(0, 9) != 0);
      ld  = ($urandom_range(0, 15) == 0);
      sy  = ($urandom_range(0, 63) == 0);
      d   = ($urandom_range(0, 20) == 0) ? $urandom_range(0, 1) : $urandom_range(2, 13);
      sel = NCH'($urandom);
      step(en, ld, sel, d, sy);
      checks++;
      if ({CLK_OUT, TICK, PENDING, ERR} !== model_vec()) begin
        failures++;
        $display("FAIL random k=%0d: got %h expected %h", k, {CLK_OUT, TICK, PENDING, ERR}, model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_load_midperiod();
    test_small_divisors();
    test_err();
    test_sync();
    test_enable_hold();
    test_reset_midperiod();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/clk_div_multi.md
# clk_div_multi

Parametrised multi-channel clock-enable/divider generator that supersedes the fixed 1 MHz divider. From one system clock it produces NCH independent divided outputs. Each output has a registered square-ish clock and a one-cycle tick strobe. Divisors are runtime-programmable per channel, and a new divisor is applied glitch-free at the channel's next wrap. A common SYNC re-aligns the phase of all channels. It sits between the board clock and slow peripherals (serializers, UART-like links, sample strobes).

## Interface
Parameters:
- NCH, 4, number of channels (1..16)
- WIDTH, 16, divisor/counter width in bits
- DEFAULT_DIV, 100, divisor loaded at reset in every channel (100 MHz CLK -> 1 MHz)

Ports:
- CLK  in  1  system clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- EN  in  1  global run enable; low freezes all counters and outputs
- LOAD  in  1  one-cycle request to program divisors
- LOAD_SEL  in  NCH  channel mask for LOAD
- DIV_IN  in  WIDTH  divisor value for LOAD
- SYNC  in  1  restart all channels at count 0 on the next edge
- CLK_OUT  out  NCH  divided clock per channel, registered
- TICK  out  NCH  one-cycle strobe on the last cycle of each period, registered
- PENDING  out  NCH  a loaded divisor is waiting for the channel wrap
- ERR  out  1  sticky flag: LOAD attempted with DIV_IN < 2

## Operation
- Per channel state: cnt[WIDTH], div[WIDTH], pend_div[WIDTH], PENDING bit.
- Counting: when EN=1, cnt steps 0,1,…,div-1,0… Each output is registered from the next count value:
  - CLK_OUT <= (cnt_next < div>>1), so it is high for floor(div/2) cycles per period.
  - TICK <= (cnt_next == div-1).
- Wrap: on the edge where cnt==div-1 and EN=1:
  - If PENDING, div <= pend_div, PENDING <= 0, and the new period starts at cnt 0 with the new divisor.
- LOAD (one-cycle pulse) with DIV_IN >= 2:
  - For each set bit of LOAD_SEL: pend_div <= DIV_IN, PENDING <= 1.
  - LOAD while already PENDING overwrites pend_div.
  - LOAD coincident with that channel's wrap: the wrap uses the new DIV_IN (DIV_IN is the value applied).
- LOAD with DIV_IN < 2: ignored in all channels, and ERR <= 1. ERR is cleared only by reset.
- SYNC=1 (with EN=1):
  - All channels go to cnt 0 on that edge, CLK_OUT=1, TICK=0.
  - Any PENDING divisor is applied immediately and PENDING is cleared.
  - SYNC and LOAD in the same cycle: the new DIV_IN is applied immediately to the selected channels.
- EN=0:
  - cnt, CLK_OUT and PENDING hold; TICK is forced 0.
  - LOAD is still accepted into pend_div/PENDING.
  - SYNC is ignored.
- Divisor range: 2..2^WIDTH-1. No divide-by-1 mode.

## Timing
- Reset (RESET=0, asynchronous):
  - cnt = DEFAULT_DIV-1, div = DEFAULT_DIV, PENDING = 0.
  - CLK_OUT = 0, TICK = 0, ERR = 0.
- First enabled edge after reset release wraps to cnt 0, so CLK_OUT = 1 and TICK = 0 in every channel. All channels therefore start phase-aligned.
- Output latency: 0 cycles relative to cnt. CLK_OUT and TICK change on the same edge as cnt, with no combinational path from inputs to outputs.
- PENDING rises on the edge that samples LOAD, and falls on the wrap edge that applies the divisor.
- Reset asserted mid-period: all state returns to reset values immediately. A pending divisor is discarded.
- Period (cycles) between consecutive TICK pulses equals div. TICK and the CLK_OUT rising edge are one cycle apart (TICK on cnt=div-1, rise on cnt=0).

## Test plan
- Reset then EN=1, defaults (NCH=4, DEFAULT_DIV=100) -> every CLK_OUT is high 50 cycles and low 50 cycles; TICK fires every 100 cycles, all four channels coincident.
- LOAD, LOAD_SEL=4'b0010, DIV_IN=5, mid-period at cnt=30 -> PENDING[1]=1 until ch1 wraps at cnt 99. After the wrap, ch1 runs with CLK_OUT high 2 / low 3 and TICK every 5 cycles; other channels are unchanged.
- Odd divisor 3 and minimum divisor 2 -> CLK_OUT pattern 1,0,0 and 1,0 respectively; TICK on every 3rd and every 2nd cycle.
- LOAD DIV_IN=1 -> ERR=1 and stays 1, divisors unchanged, PENDING unchanged; a later valid LOAD still works and ERR remains 1.
- Channels at divisors 7 and 10, SYNC pulse -> both channels report cnt 0 / CLK_OUT=1 on the next edge. SYNC together with LOAD of DIV_IN=4 to ch0 -> ch0 is immediately on period 4 with PENDING[0]=0.
- EN low for 20 cycles mid-period -> CLK_OUT held, TICK=0, phase resumes exactly. RESET pulsed low mid-period with PENDING set -> outputs 0 asynchronously, PENDING cleared, DEFAULT_DIV restored.
